// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Opcodes, state encodings and datapath select encodings shared
//               by the multicycle MIPS control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam logic [5:0] c_OP_R   = 6'b000000;
    localparam logic [5:0] c_OP_LW  = 6'b100011;
    localparam logic [5:0] c_OP_SW  = 6'b101011;
    localparam logic [5:0] c_OP_BEQ = 6'b000100;
    localparam logic [5:0] c_OP_J   = 6'b000010;

    localparam logic [3:0] c_ST_FETCH  = 4'd0;
    localparam logic [3:0] c_ST_DECODE = 4'd1;
    localparam logic [3:0] c_ST_MEMADR = 4'd2;
    localparam logic [3:0] c_ST_MEMRD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB  = 4'd4;
    localparam logic [3:0] c_ST_MEMWR  = 4'd5;
    localparam logic [3:0] c_ST_EXEC   = 4'd6;
    localparam logic [3:0] c_ST_RWB    = 4'd7;
    localparam logic [3:0] c_ST_BRANCH = 4'd8;
    localparam logic [3:0] c_ST_JUMP   = 4'd9;

    localparam logic [1:0] c_SRCB_B    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR = 2'b01;
    localparam logic [1:0] c_SRCB_SEXT = 2'b10;
    localparam logic [1:0] c_SRCB_SHL2 = 2'b11;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_decode
// Description : Combinational next-state and control-output decode for the
//               multicycle MIPS FSM. MIPS_CTRL_JUMP_EN builds the JUMP state.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [3:0]      i_state,
    input  logic [OP_W-1:0] i_opcode,
    input  logic            i_ready,
    output logic [3:0]      o_next_state,
    output ctrl_t           o_ctrl,
    output logic            o_illegal,
    output logic            o_retire
);

    logic w_is_r;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_beq;
    logic w_legal;

    assign w_is_r   = (i_opcode == OP_W'(c_OP_R));
    assign w_is_lw  = (i_opcode == OP_W'(c_OP_LW));
    assign w_is_sw  = (i_opcode == OP_W'(c_OP_SW));
    assign w_is_beq = (i_opcode == OP_W'(c_OP_BEQ));

`ifdef MIPS_CTRL_JUMP_EN
    logic w_is_j;
    assign w_is_j  = (i_opcode == OP_W'(c_OP_J));
    assign w_legal = w_is_r | w_is_lw | w_is_sw | w_is_beq | w_is_j;
`else
    assign w_legal = w_is_r | w_is_lw | w_is_sw | w_is_beq;
`endif

    // Next state and retire strobe; retire marks the edge leaving a final state.
    always_comb begin
        o_next_state = c_ST_FETCH;
        o_retire     = 1'b0;
        case (i_state)
            c_ST_FETCH:  o_next_state = i_ready ? c_ST_DECODE : c_ST_FETCH;
            c_ST_DECODE: begin
                if (w_is_lw || w_is_sw) o_next_state = c_ST_MEMADR;
                else if (w_is_r)        o_next_state = c_ST_EXEC;
                else if (w_is_beq)      o_next_state = c_ST_BRANCH;
`ifdef MIPS_CTRL_JUMP_EN
                else if (w_is_j)        o_next_state = c_ST_JUMP;
`endif
            end
            c_ST_MEMADR: o_next_state = w_is_sw ? c_ST_MEMWR : c_ST_MEMRD;
            c_ST_MEMRD:  o_next_state = i_ready ? c_ST_MEMWB : c_ST_MEMRD;
            c_ST_MEMWB:  o_retire     = 1'b1;
            c_ST_MEMWR: begin
                o_next_state = i_ready ? c_ST_FETCH : c_ST_MEMWR;
                o_retire     = i_ready;
            end
            c_ST_EXEC:   o_next_state = c_ST_RWB;
            c_ST_RWB:    o_retire     = 1'b1;
            c_ST_BRANCH: o_retire     = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
            c_ST_JUMP:   o_retire     = 1'b1;
`endif
            default:     o_next_state = c_ST_FETCH;
        endcase
    end

    // Moore outputs, with FETCH's IR/PC loads gated by the memory handshake.
    always_comb begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
        case (i_state)
            c_ST_FETCH: begin
                o_ctrl.memread = 1'b1;
                o_ctrl.alusrcb = c_SRCB_FOUR;
                o_ctrl.irwrite = i_ready;
                o_ctrl.pcwrite = i_ready;
            end
            c_ST_DECODE: begin
                o_ctrl.alusrcb = c_SRCB_SHL2;
                o_illegal      = ~w_legal;
            end
            c_ST_MEMADR: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = c_SRCB_SEXT;
            end
            c_ST_MEMRD: begin
                o_ctrl.memread = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            c_ST_MEMWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.memtoreg = 1'b1;
            end
            c_ST_MEMWR: begin
                o_ctrl.memwrite = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            c_ST_EXEC: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = c_SRCB_B;
                o_ctrl.aluop   = c_ALUOP_FUNCT;
            end
            c_ST_RWB: begin
                o_ctrl.regwrite = 1'b1;
                o_ctrl.regdst   = 1'b1;
            end
            c_ST_BRANCH: begin
                o_ctrl.alusrca     = 1'b1;
                o_ctrl.alusrcb     = c_SRCB_B;
                o_ctrl.aluop       = c_ALUOP_SUB;
                o_ctrl.pcwritecond = 1'b1;
                o_ctrl.pcsource    = c_PCSRC_ALUOUT;
            end
`ifdef MIPS_CTRL_JUMP_EN
            c_ST_JUMP: begin
                o_ctrl.pcwrite  = 1'b1;
                o_ctrl.pcsource = c_PCSRC_JUMP;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_control
// Description : Multicycle MIPS control FSM with memory-ready stalls and a
//               retired-instruction counter. MIPS_CTRL_JUMP_EN enables J.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int USE_HANDSHAKE = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_next_state;
    ctrl_t            w_ctrl;
    ctrl_t            w_ctrl_out;
    logic             w_illegal;
    logic             w_retire;
    logic             w_ready;

    assign w_ready = (USE_HANDSHAKE != 0) ? mem_ready : 1'b1;

    mips_ctrl_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .i_state      (r_state),
        .i_opcode     (opcode),
        .i_ready      (w_ready),
        .o_next_state (w_next_state),
        .o_ctrl       (w_ctrl),
        .o_illegal    (w_illegal),
        .o_retire     (w_retire)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_FETCH;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (rst)           r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

    // Reset blanks every datapath control so nothing is written mid-reset.
    assign w_ctrl_out  = rst ? '0 : w_ctrl;
    assign illegal_op  = w_illegal & ~rst;

    assign PCWrite     = w_ctrl_out.pcwrite;
    assign PCWriteCond = w_ctrl_out.pcwritecond;
    assign IorD        = w_ctrl_out.iord;
    assign MemRead     = w_ctrl_out.memread;
    assign MemWrite    = w_ctrl_out.memwrite;
    assign IRWrite     = w_ctrl_out.irwrite;
    assign MemtoReg    = w_ctrl_out.memtoreg;
    assign RegDst      = w_ctrl_out.regdst;
    assign RegWrite    = w_ctrl_out.regwrite;
    assign ALUSrcA     = w_ctrl_out.alusrca;
    assign ALUSrcB     = w_ctrl_out.alusrcb;
    assign ALUOp       = w_ctrl_out.aluop;
    assign PCSource    = w_ctrl_out.pcsource;
    assign retired     = r_retired;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Self-checking bench for the multicycle MIPS control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

`ifdef MIPS_CTRL_JUMP_EN
    localparam bit c_JUMP_EN = 1'b1;
`else
    localparam bit c_JUMP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] ph;
        logic       rdy;
    } step_t;

    logic        clk = 1'b0;
    logic        rst, mem_ready;
    logic [5:0]  opcode;
    logic        pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, ill;
    logic [1:0]  srcb, aluop, pcsrc;
    logic [31:0] retired;
    logic [3:0]  state;

    logic        rst_w, mem_ready_w;
    logic [5:0]  opcode_w;
    logic        pcw_w, pcwc_w, iord_w, mrd_w, mwr_w, irw_w, m2r_w, rdst_w, rwr_w, srca_w, ill_w;
    logic [1:0]  srcb_w, aluop_w, pcsrc_w;
    logic [3:0]  retired_w;
    logic [3:0]  state_w;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_ret = '0;
    int          model_ret_w = 0;
    step_t       plan[$];
    logic [16:0] obs_ctrl;

    always #5 clk = ~clk;

    assign obs_ctrl = {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aluop, pcsrc, ill};

    mips_multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
        .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rwr), .ALUSrcA(srca),
        .ALUSrcB(srcb), .ALUOp(aluop), .PCSource(pcsrc), .illegal_op(ill),
        .retired(retired), .state(state)
    );

    mips_multicycle_control #(.USE_HANDSHAKE(0), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst_w), .opcode(opcode_w), .mem_ready(mem_ready_w),
        .PCWrite(pcw_w), .PCWriteCond(pcwc_w), .IorD(iord_w), .MemRead(mrd_w), .MemWrite(mwr_w),
        .IRWrite(irw_w), .MemtoReg(m2r_w), .RegDst(rdst_w), .RegWrite(rwr_w), .ALUSrcA(srca_w),
        .ALUSrcB(srcb_w), .ALUOp(aluop_w), .PCSource(pcsrc_w), .illegal_op(ill_w),
        .retired(retired_w), .state(state_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return (op == c_OP_R) || (op == c_OP_LW) || (op == c_OP_SW) ||
               (op == c_OP_BEQ) || (c_JUMP_EN && op == c_OP_J);
    endfunction

    // Expected control word for one cycle of a phase, straight from the state table.
    function automatic logic [16:0] exp_vec(input logic [3:0] ph, input logic rdy, input logic il);
        logic pw, pwc, io, mr, mw, ir, mtr, rd, rw, sa;
        logic [1:0] sb, op, ps;
        {pw, pwc, io, mr, mw, ir, mtr, rd, rw, sa} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (ph)
            c_ST_FETCH:  begin mr = 1'b1; sb = 2'b01; ir = rdy; pw = rdy; end
            c_ST_DECODE: sb = 2'b11;
            c_ST_MEMADR: begin sa = 1'b1; sb = 2'b10; end
            c_ST_MEMRD:  begin mr = 1'b1; io = 1'b1; end
            c_ST_MEMWB:  begin rw = 1'b1; mtr = 1'b1; end
            c_ST_MEMWR:  begin mw = 1'b1; io = 1'b1; end
            c_ST_EXEC:   begin sa = 1'b1; op = 2'b10; end
            c_ST_RWB:    begin rw = 1'b1; rd = 1'b1; end
            c_ST_BRANCH: begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
            c_ST_JUMP:   begin pw = 1'b1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, ir, mtr, rd, rw, sa, sb, op, ps, il};
    endfunction

    task automatic build(input logic [5:0] op, input int fw, input int mw);
        plan.delete();
        for (int i = 0; i < fw; i++) plan.push_back('{c_ST_FETCH, 1'b0});
        plan.push_back('{c_ST_FETCH, 1'b1});
        plan.push_back('{c_ST_DECODE, 1'($urandom)});
        if (!is_legal(op)) return;
        if (op == c_OP_R) begin
            plan.push_back('{c_ST_EXEC, 1'($urandom)});
            plan.push_back('{c_ST_RWB, 1'($urandom)});
        end else if (op == c_OP_LW || op == c_OP_SW) begin
            plan.push_back('{c_ST_MEMADR, 1'($urandom)});
            for (int i = 0; i < mw; i++)
                plan.push_back('{(op == c_OP_LW) ? c_ST_MEMRD : c_ST_MEMWR, 1'b0});
            plan.push_back('{(op == c_OP_LW) ? c_ST_MEMRD : c_ST_MEMWR, 1'b1});
            if (op == c_OP_LW) plan.push_back('{c_ST_MEMWB, 1'($urandom)});
        end else if (op == c_OP_BEQ) begin
            plan.push_back('{c_ST_BRANCH, 1'($urandom)});
        end else begin
            plan.push_back('{c_ST_JUMP, 1'($urandom)});
        end
    endtask

    // Runs the first 'limit' cycles of the plan (limit < 0 runs it all and retires).
    task automatic run_plan(input logic [5:0] op, input int limit);
        int n;
        n = (limit < 0 || limit > plan.size()) ? plan.size() : limit;
        for (int k = 0; k < n; k++) begin
            mem_ready = plan[k].rdy;
            opcode    = (plan[k].ph == c_ST_FETCH) ? 6'($urandom) : op;
            #1;
            check("state", 32'(state), 32'(plan[k].ph));
            check("ctrl", 32'(obs_ctrl),
                  32'(exp_vec(plan[k].ph, plan[k].rdy, plan[k].ph == c_ST_DECODE && !is_legal(op))));
            check("retired", retired, model_ret);
            @(posedge clk); #1;
        end
        if (limit < 0 && is_legal(op)) model_ret = model_ret + 1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        build(op, fw, mw);
        run_plan(op, -1);
    endtask

    initial begin
        logic [5:0] op;
        rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0;
        rst_w = 1'b1; mem_ready_w = 1'b0; opcode_w = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        check("reset_state", 32'(state), 32'(c_ST_FETCH));
        check("reset_retired", retired, 32'd0);
        check("reset_ctrl", 32'(obs_ctrl), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios.
        run_instr(c_OP_R, 0, 0);
        run_instr(c_OP_LW, 0, 2);
        run_instr(c_OP_SW, 0, 0);
        run_instr(c_OP_BEQ, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(c_OP_J, 0, 0);
        run_instr(c_OP_R, 2, 0);

        // Reset while LW is stalled in MEMRD.
        build(c_OP_LW, 0, 5);
        run_plan(c_OP_LW, 5);
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        check("rst_ctrl", 32'(obs_ctrl), 32'd0);
        @(posedge clk); #1;
        check("rst_state", 32'(state), 32'(c_ST_FETCH));
        check("rst_retired", retired, 32'd0);
        check("rst_ctrl_hold", 32'(obs_ctrl), 32'd0);
        rst = 1'b0;
        model_ret = '0;

        // Random instruction stream.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: op = c_OP_R;
                1: op = c_OP_LW;
                2: op = c_OP_SW;
                3: op = c_OP_BEQ;
                4: op = c_OP_J;
                default: op = 6'($urandom);
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        mem_ready = 1'b1;
        #1;
        check("final_retired", retired, model_ret);
        rst = 1'b1;

        // Narrow counter, handshake ignored, mem_ready held low.
        @(posedge clk); #1;
        rst_w = 1'b0; opcode_w = c_OP_R;
        #1;
        check("nohs_irwrite", 32'(irw_w), 32'd1);
        for (int i = 0; i < 17; i++) begin
            repeat (4) @(posedge clk);
            model_ret_w++;
            #1;
            check("wrap_retired", 32'(retired_w), 32'(model_ret_w % 16));
        end
        check("wrap_17", 32'(retired_w), 32'd1);
        opcode_w = c_OP_LW;
        check("nohs_s0", 32'(state_w), 32'(c_ST_FETCH));
        @(posedge clk); #1; check("nohs_s1", 32'(state_w), 32'(c_ST_DECODE));
        @(posedge clk); #1; check("nohs_s2", 32'(state_w), 32'(c_ST_MEMADR));
        @(posedge clk); #1; check("nohs_s3", 32'(state_w), 32'(c_ST_MEMRD));
        @(posedge clk); #1; check("nohs_s4", 32'(state_w), 32'(c_ST_MEMWB));
        @(posedge clk); #1; check("nohs_done", 32'(state_w), 32'(c_ST_FETCH));
        check("nohs_retired", 32'(retired_w), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
